led_frame_tx: RTL and testbench

Parametrised visible-light frame transmitter: buffers up to DEPTH frames in an internal FIFO and Manchester-encodes each one onto the LED output. Each frame is preceded by a preamble and followed by an idle gap. The bit rate is programmable at run time. It replaces the single-frame encoder plus top-level start/irq loop: the top level only pushes frames and counts irq pulses.

---
 rtl/led_frame_tx.sv | 199 +++++++++++++++++++
 tb/tb_led_frame_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_tx.sv
// led_frame_tx: queued Manchester frame transmitter for a visible-light link.
// Frames wait in a small FIFO and go out as preamble, payload, idle gap.
module led_frame_tx #(
    parameter int   FRAME_SIZE    = 16,
    parameter int   DEPTH         = 4,
    parameter int   DIV_W         = 16,
    parameter int   PREAMBLE_BITS = 8,
    parameter int   GAP_HALVES    = 4,
    parameter logic IDLE_LEVEL    = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DIV_W-1:0]        half_period,
    input  logic                    enable,
    input  logic                    push,
    input  logic [FRAME_SIZE-1:0]   push_data,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    drop,
    output logic                    led,
    output logic                    busy,
    output logic                    irq
);

    localparam int AW   = $clog2(DEPTH);
    localparam int TW   = DIV_W + $clog2(GAP_HALVES + 1);
    localparam int MAXB = (PREAMBLE_BITS > FRAME_SIZE) ? PREAMBLE_BITS : FRAME_SIZE;
    localparam int BW   = $clog2(MAXB + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRE,
        S_DATA,
        S_GAP
    } state_t;

    state_t state, state_nxt;

    logic [FRAME_SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push_ok;
    logic                  pop;

    logic [DIV_W-1:0]      h_eff;
    logic [DIV_W-1:0]      h_lat;
    logic [TW-1:0]         tmr;
    logic [TW-1:0]         half_load;
    logic [TW-1:0]         gap_load;
    logic                  phase;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_SIZE-1:0] shreg;
    logic                  half_end;
    logic                  bit_end;
    logic                  pre_last;
    logic                  data_last;
    logic                  cur_bit;

    assign full    = (count == (AW+1)'(DEPTH));
    assign push_ok = push && !full;

    assign h_eff     = (half_period == '0) ? DIV_W'(1) : half_period;
    assign half_load = TW'(h_lat) - TW'(1);
    assign gap_load  = TW'(GAP_HALVES) * TW'(h_lat) - TW'(1);
    assign half_end  = (tmr == '0);
    assign bit_end   = half_end && phase;
    assign pre_last  = (bit_cnt == BW'(PREAMBLE_BITS - 1));
    assign data_last = (bit_cnt == BW'(FRAME_SIZE - 1));
    // Preamble starts with a 1, so even bit indices carry 1.
    assign cur_bit   = (state == S_PRE) ? ~bit_cnt[0] : shreg[FRAME_SIZE-1];

    // Frame storage; contents need no reset since pointers gate reads.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers, occupancy and rejected-push pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
        end else begin
            drop <= push && full;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (enable && count != '0) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_PRE;
            S_PRE:  if (bit_end && pre_last) state_nxt = S_DATA;
            S_DATA: if (bit_end && data_last) state_nxt = S_GAP;
            S_GAP:  if (half_end) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = 1'b0;
        pop  = 1'b0;
        case (state)
            S_IDLE: busy = 1'b0;
            S_LOAD: begin
                busy = 1'b1;
                pop  = 1'b1;
            end
            default: busy = 1'b1;
        endcase
    end

    // Half-bit timer, bit sequencing and registered line level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led     <= IDLE_LEVEL;
            irq     <= 1'b0;
            tmr     <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
            h_lat   <= DIV_W'(1);
        end else begin
            irq <= 1'b0;
            case (state)
                S_LOAD: begin
                    shreg   <= mem[rd_ptr];
                    h_lat   <= h_eff;
                    tmr     <= TW'(h_eff) - TW'(1);
                    phase   <= 1'b0;
                    bit_cnt <= '0;
                    led     <= 1'b1;
                end
                S_PRE, S_DATA: begin
                    if (!half_end) begin
                        tmr <= tmr - TW'(1);
                    end else if (!phase) begin
                        phase <= 1'b1;
                        led   <= ~cur_bit;
                        tmr   <= half_load;
                    end else begin
                        phase <= 1'b0;
                        tmr   <= half_load;
                        if (state == S_PRE) begin
                            if (pre_last) begin
                                bit_cnt <= '0;
                                led     <= shreg[FRAME_SIZE-1];
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                                led     <= bit_cnt[0];
                            end
                        end else begin
                            if (data_last) begin
                                bit_cnt <= '0;
                                led     <= IDLE_LEVEL;
                                irq     <= 1'b1;
                                tmr     <= gap_load;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                                shreg   <= shreg << 1;
                                led     <= shreg[FRAME_SIZE-2];
                            end
                        end
                    end
                end
                S_GAP: begin
                    led <= IDLE_LEVEL;
                    if (!half_end) begin
                        tmr <= tmr - TW'(1);
                    end
                end
                default: led <= IDLE_LEVEL;
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_tx.sv
// tb_led_frame_tx: table vectors plus multi-cycle sequences for led_frame_tx.
// Pushed frames go to a scoreboard queue and are checked on the line.
module tb_led_frame_tx;

    localparam int FS    = 16;
    localparam int DEPTH = 4;
    localparam int DIV_W = 16;
    localparam int PB    = 8;
    localparam int GH    = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [DIV_W-1:0] half_period = '0;
    logic             enable = 1'b0;
    logic             push = 1'b0;
    logic [FS-1:0]    push_data = '0;
    logic             full;
    logic [2:0]       count;
    logic             drop;
    logic             led;
    logic             busy;
    logic             irq;

    int checks = 0;
    int errors = 0;
    int irq_seen = 0;
    int mcount = 0;
    logic [FS-1:0] exp_q[$];

    typedef struct {
        logic [DIV_W-1:0] hp;
        logic [FS-1:0]    data;
        int               exp_h;
    } vec_t;

    vec_t vecs[4];

    led_frame_tx #(
        .FRAME_SIZE(FS),
        .DEPTH(DEPTH),
        .DIV_W(DIV_W),
        .PREAMBLE_BITS(PB),
        .GAP_HALVES(GH),
        .IDLE_LEVEL(1'b0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .half_period(half_period),
        .enable(enable),
        .push(push),
        .push_data(push_data),
        .full(full),
        .count(count),
        .drop(drop),
        .led(led),
        .busy(busy),
        .irq(irq)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (irq) irq_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_level(input logic [FS-1:0] d, input int h, input int i);
        int hf;
        int b;
        logic v;
        hf = i / h;
        b = hf / 2;
        if (b < PB) v = (b % 2 == 0);
        else v = d[FS-1-(b-PB)];
        return (hf % 2 == 1) ? ~v : v;
    endfunction

    task automatic do_push(input logic [FS-1:0] d);
        logic exp_drop;
        exp_drop = (mcount == DEPTH);
        push_data = d;
        push = 1'b1;
        @(negedge clock);
        push = 1'b0;
        if (!exp_drop) begin
            mcount++;
            exp_q.push_back(d);
        end
        check("drop", drop, exp_drop);
    endtask

    task automatic check_frame(input int h, output int waited);
        logic [FS-1:0] d;
        int n;
        int bad;
        int irq0;
        waited = 0;
        while (!busy && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        if (!busy) begin
            check("load_timeout", 0, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        d = exp_q.pop_front();
        mcount--;
        irq0 = irq_seen;
        n = 2 * h * (PB + FS);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (led !== exp_level(d, h, i) || irq !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("frame_wave_bad_cycles", bad, 0);
        @(negedge clock);
        check("irq_first_gap", irq, 1);
        check("gap_led", led, 0);
        bad = 0;
        for (int i = 1; i < GH * h; i++) begin
            @(negedge clock);
            if (led !== 1'b0 || irq !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("gap_cycles", bad, 0);
        @(negedge clock);
        check("busy_fall", busy, 0);
        check("irq_once", irq_seen - irq0, 1);
    endtask

    initial begin
        int w;
        int i0;
        int n;
        int bad;

        vecs[0] = '{hp: 16'd2, data: 16'h5555, exp_h: 2};
        vecs[1] = '{hp: 16'd0, data: 16'hA5C3, exp_h: 1};
        vecs[2] = '{hp: 16'd1, data: 16'hFFFF, exp_h: 1};
        vecs[3] = '{hp: 16'd3, data: 16'h0001, exp_h: 3};

        repeat (3) @(negedge clock);
        check("rst_led", led, 0);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_drop", drop, 0);
        check("rst_busy", busy, 0);
        check("rst_irq", irq, 0);
        reset = 1'b1;
        @(negedge clock);

        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            half_period = vecs[i].hp;
            do_push(vecs[i].data);
            check("count_after_push", count, 1);
            check_frame(vecs[i].exp_h, w);
            check("load_latency", w, 1);
            check("count_idle", count, 0);
        end

        enable = 1'b0;
        half_period = 16'd1;
        i0 = irq_seen;
        for (int k = 0; k < 5; k++) begin
            do_push(16'h1000 + 16'(k) * 16'h0111);
            if (k == 3) check("full_after_4", full, 1);
        end
        check("count_after_drop", count, 4);
        check("full_hold", full, 1);
        check("idle_while_disabled", busy, 0);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_frame(1, w);
            if (k > 0) check("b2b_spacing", w, 1);
        end
        check("irq_total", irq_seen - i0, 4);
        check("count_drained", count, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        half_period = 16'd2;
        do_push(16'hC3A5);
        do_push(16'h5A3C);
        fork
            check_frame(2, w);
            begin
                repeat (20) @(negedge clock);
                half_period = 16'd5;
            end
        join
        check_frame(5, w);

        half_period = 16'd1;
        do_push(16'h9C31);
        do_push(16'h4E72);
        fork
            check_frame(1, w);
            begin
                repeat (30) @(negedge clock);
                enable = 1'b0;
            end
        join
        repeat (20) @(negedge clock);
        check("busy_hold_low", busy, 0);
        check("count_queued", count, 1);
        enable = 1'b1;
        check_frame(1, w);

        do_push(16'hFFFF);
        do_push(16'h1234);
        repeat (20) @(negedge clock);
        n = 0;
        while (!led && n < 4) begin
            @(negedge clock);
            n++;
        end
        check("pre_reset_busy", busy, 1);
        check("pre_reset_led", led, 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_led", led, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_count", count, 0);
        check("async_rst_full", full, 0);
        check("async_rst_irq", irq, 0);
        exp_q.delete();
        mcount = 0;
        @(negedge clock);
        reset = 1'b1;
        i0 = irq_seen;
        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (busy !== 1'b0 || led !== 1'b0) bad++;
        end
        check("quiet_after_reset", bad, 0);
        check("irq_after_reset", irq_seen - i0, 0);
        do_push(16'h0F0F);
        check_frame(1, w);
        check("load_latency_post_reset", w, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
